// File: rtl/cpu_dbus_arbiter_pkg.sv
// Shared types for the CPU data-bus arbiter: FSM state and pointer sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dbus_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dbus_arb_state_t;

    // A one-master index still needs one bit to stay a legal vector.
    localparam int MIN_PTR_W = 1;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : MIN_PTR_W;
    endfunction

endpackage

// File: rtl/cpu_dbus_arbiter_if.sv
// CPU data-bus bundle for N requesters (N=1 for the single slave-side port).
// Latency: n/a (wires only).
// Backpressure: stall / uncached_stall per requester, rddata broadcast.
interface cpu_dbus_arbiter_if #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [N_MASTERS-1:0]                   read;
    logic [N_MASTERS-1:0]                   write;
    logic [N_MASTERS-1:0]                   uncached_read;
    logic [N_MASTERS-1:0]                   uncached_write;
    logic [N_MASTERS-1:0]                   icache_inv;
    logic [N_MASTERS-1:0]                   dcache_inv;
    logic [N_MASTERS-1:0][ADDR_WIDTH-1:0]   address;
    logic [N_MASTERS-1:0][DATA_WIDTH-1:0]   wrdata;
    logic [N_MASTERS-1:0][DATA_WIDTH/8-1:0] byteenable;
    logic [N_MASTERS-1:0]                   stall;
    logic [N_MASTERS-1:0]                   uncached_stall;
    logic [DATA_WIDTH-1:0]                  rddata;
    logic [DATA_WIDTH-1:0]                  uncached_rddata;

    // Requester side: issues strobes, receives stalls and read data.
    modport master (
        output read, write, uncached_read, uncached_write, icache_inv, dcache_inv,
        output address, wrdata, byteenable,
        input  stall, uncached_stall, rddata, uncached_rddata
    );

    // Responder side: receives strobes, returns stalls and read data.
    modport slave (
        input  read, write, uncached_read, uncached_write, icache_inv, dcache_inv,
        input  address, wrdata, byteenable,
        output stall, uncached_stall, rddata, uncached_rddata
    );
endinterface

// File: rtl/cpu_dbus_arbiter_rr_picker.sv
// Picks the first requester at or after ptr, wrapping (or lowest index with DBUS_ARB_FIXED_PRIO_EN).
// Latency: purely combinational.
// Backpressure: none; valid is low when nobody requests.
module rr_picker
    import dbus_arb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

`ifdef DBUS_ARB_FIXED_PRIO_EN
    // Pointer has no say in fixed priority.
    wire unused_ptr = ^ptr;

    // Lowest requesting index wins; scanning downward lets it overwrite last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[PW'(k)]) begin
                valid = 1'b1;
                idx   = PW'(k);
            end
        end
    end
`else
    // Scan offsets from far to near so the nearest requester after ptr wins.
    always_comb begin
        logic [PW-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/cpu_dbus_arbiter.sv
// Round-robin N:1 arbiter merging CPU data-bus masters onto one D$/uncached port; grant locked until completion. Option: DBUS_ARB_FIXED_PRIO_EN.
// Latency: grant registered (request in IDLE forwarded next cycle); back-to-back handover without bubble; rddata combinational.
// Backpressure: owner sees slave stalls, every other requester is stalled by its own strobes.
module cpu_dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    cpu_dbus_arbiter_if.slave  m,
    cpu_dbus_arbiter_if.master s
);

    localparam int PW = ptr_width(N_MASTERS);

    dbus_arb_state_t        state, state_nxt;
    logic [PW-1:0]          owner, owner_nxt;
    logic [PW-1:0]          ptr, ptr_nxt;
    logic [PW-1:0]          owner_inc, pick_ptr, pick_idx;
    logic                   pick_vld;
    logic                   busy, own_cached, own_unc, own_release;
    logic [N_MASTERS-1:0]   cached_req, unc_req, req;
    logic [ADDR_WIDTH-1:0]  own_address;
    logic [DATA_WIDTH-1:0]  own_wrdata;
    logic [DATA_WIDTH/8-1:0] own_byteenable;

    assign cached_req = m.read | m.write | m.icache_inv | m.dcache_inv;
    assign unc_req    = m.uncached_read | m.uncached_write;
    assign req        = cached_req | unc_req;
    assign busy       = (state == BUSY);

    // Owner is done once every path it uses is unstalled; an owner with no
    // strobes left (flush) satisfies this trivially and is released too.
    assign own_cached  = cached_req[owner];
    assign own_unc     = unc_req[owner];
    assign own_release = (!own_cached || !s.stall[0]) && (!own_unc || !s.uncached_stall[0]);

    assign owner_inc = (owner == PW'(N_MASTERS - 1)) ? '0 : owner + PW'(1);
    // While busy the search already starts past the owner, so the handover
    // decision uses the pointer value being committed this cycle.
    assign pick_ptr  = busy ? owner_inc : ptr;

    rr_picker #(.N(N_MASTERS)) u_picker (
        .req   (req),
        .ptr   (pick_ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // State, owner and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Grant on request from IDLE; on release advance pointer and hand over or go idle.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = BUSY;
                    owner_nxt = pick_idx;
                end
            end
            BUSY: begin
                if (own_release) begin
                    ptr_nxt = owner_inc;
                    if (pick_vld) begin
                        owner_nxt = pick_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign own_address    = m.address[owner];
    assign own_wrdata     = m.wrdata[owner];
    assign own_byteenable = m.byteenable[owner];

    // Slave side mirrors the owner; everything is zero when idle or in reset.
    assign s.read[0]           = busy & m.read[owner];
    assign s.write[0]          = busy & m.write[owner];
    assign s.uncached_read[0]  = busy & m.uncached_read[owner];
    assign s.uncached_write[0] = busy & m.uncached_write[owner];
    assign s.icache_inv[0]     = busy & m.icache_inv[owner];
    assign s.dcache_inv[0]     = busy & m.dcache_inv[owner];
    assign s.address[0]        = busy ? own_address    : '0;
    assign s.wrdata[0]         = busy ? own_wrdata     : '0;
    assign s.byteenable[0]     = busy ? own_byteenable : '0;

    assign m.rddata          = s.rddata;
    assign m.uncached_rddata = s.uncached_rddata;

    // Non-owners are held by their own strobes; the owner sees the slave stalls.
    always_comb begin
        m.stall          = cached_req;
        m.uncached_stall = unc_req;
        if (busy) begin
            m.stall[owner]          = s.stall[0];
            m.uncached_stall[owner] = s.uncached_stall[0];
        end
    end

endmodule

// File: tb/tb_cpu_dbus_arbiter.sv
// Bench for cpu_dbus_arbiter: directed scenarios on N=2 and N=3 instances plus a random run against a reference model.
// Latency: n/a.
// Backpressure: slave stalls are driven randomly or per scenario.
module tb_cpu_dbus_arbiter;
    import dbus_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int NA = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cpu_dbus_arbiter_if #(.N_MASTERS(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ma ();
    cpu_dbus_arbiter_if #(.N_MASTERS(1),  .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sa ();
    cpu_dbus_arbiter_if #(.N_MASTERS(3),  .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mb ();
    cpu_dbus_arbiter_if #(.N_MASTERS(1),  .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sb ();

    cpu_dbus_arbiter #(.N_MASTERS(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_a (
        .clk(clk), .rst_n(rst_n), .m(ma), .s(sa));
    cpu_dbus_arbiter #(.N_MASTERS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_b (
        .clk(clk), .rst_n(rst_n), .m(mb), .s(sb));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic clear_inputs();
        ma.read = '0; ma.write = '0; ma.uncached_read = '0; ma.uncached_write = '0;
        ma.icache_inv = '0; ma.dcache_inv = '0;
        ma.address = '0; ma.wrdata = '0; ma.byteenable = '0;
        mb.read = '0; mb.write = '0; mb.uncached_read = '0; mb.uncached_write = '0;
        mb.icache_inv = '0; mb.dcache_inv = '0;
        mb.address = '0; mb.wrdata = '0; mb.byteenable = '0;
        sa.stall = '0; sa.uncached_stall = '0; sa.rddata = '0; sa.uncached_rddata = '0;
        sb.stall = '0; sb.uncached_stall = '0; sb.rddata = '0; sb.uncached_rddata = '0;
    endtask

    // Leaves the bench at a falling edge with reset released (cycle 0).
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference arbitration rule: first requester from p upward, wrapping.
    function automatic int ref_pick(input logic [NA-1:0] rq, input int p);
`ifdef DBUS_ARB_FIXED_PRIO_EN
        for (int j = 0; j < NA; j++) if (rq[j]) return j;
`else
        for (int k = 0; k < NA; k++) if (rq[(p + k) % NA]) return (p + k) % NA;
`endif
        return -1;
    endfunction

    task automatic test_reset();
        logic [5:0] strobes;
        @(negedge clk);
        clear_inputs();
        ma.read[1] = 1'b1;
        ma.uncached_write[0] = 1'b1;
        sa.stall = 1'b1;
        sa.rddata = 64'h1122_3344_5566_7788;
        sa.uncached_rddata = 64'h99AA_BBCC_DDEE_F001;
        #1;
        strobes = {sa.read[0], sa.write[0], sa.uncached_read[0], sa.uncached_write[0], sa.icache_inv[0], sa.dcache_inv[0]};
        checks++; if (strobes !== 6'b0) begin errors++; $display("FAIL reset_s_strobes: got %b expected 000000", strobes); end
        checks++; if (ma.stall !== 2'b10) begin errors++; $display("FAIL reset_m_stall: got %b expected 10", ma.stall); end
        checks++; if (ma.uncached_stall !== 2'b01) begin errors++; $display("FAIL reset_m_uncached_stall: got %b expected 01", ma.uncached_stall); end
        checks++; if (ma.rddata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL reset_rddata: got %h expected 1122334455667788", ma.rddata); end
        checks++; if (ma.uncached_rddata !== 64'h99AA_BBCC_DDEE_F001) begin errors++; $display("FAIL reset_uncached_rddata: got %h expected 99aabbccddeef001", ma.uncached_rddata); end
        checks++; if (dut_a.state !== IDLE || dut_a.ptr !== 1'b0 || dut_a.owner !== 1'b0) begin errors++; $display("FAIL reset_fsm: got state %b ptr %b owner %b expected 0 0 0", dut_a.state, dut_a.ptr, dut_a.owner); end
        @(posedge clk); #1;
        checks++; if (sa.read[0] !== 1'b0 || sa.uncached_write[0] !== 1'b0) begin errors++; $display("FAIL reset_hold: got read %b uwrite %b expected 0 0", sa.read[0], sa.uncached_write[0]); end
    endtask

    task automatic test_single_read();
        apply_reset();
        ma.read[0] = 1'b1;
        ma.address[0] = 32'h0000_1000;
        sa.stall = 1'b1;
        #1;
        checks++; if (sa.read[0] !== 1'b0) begin errors++; $display("FAIL single_c0_s_read: got %b expected 0", sa.read[0]); end
        checks++; if (ma.stall[0] !== 1'b1) begin errors++; $display("FAIL single_c0_stall: got %b expected 1", ma.stall[0]); end
        @(negedge clk); #1;
        checks++; if (sa.read[0] !== 1'b1 || sa.address[0] !== 32'h0000_1000) begin errors++; $display("FAIL single_c1_fwd: got read %b addr %h expected 1 00001000", sa.read[0], sa.address[0]); end
        checks++; if (ma.stall[0] !== 1'b1) begin errors++; $display("FAIL single_c1_stall: got %b expected 1", ma.stall[0]); end
        @(negedge clk); #1;
        checks++; if (ma.stall[0] !== 1'b1) begin errors++; $display("FAIL single_c2_stall: got %b expected 1", ma.stall[0]); end
        @(negedge clk);
        sa.stall = 1'b0;
        sa.rddata = 64'hCAFE_F00D_1234_5678;
        #1;
        checks++; if (ma.stall[0] !== 1'b0) begin errors++; $display("FAIL single_c3_stall: got %b expected 0", ma.stall[0]); end
        checks++; if (ma.rddata !== 64'hCAFE_F00D_1234_5678) begin errors++; $display("FAIL single_c3_rddata: got %h expected cafef00d12345678", ma.rddata); end
        @(negedge clk);
        ma.read[0] = 1'b0;
        #1;
        checks++; if (sa.read[0] !== 1'b0) begin errors++; $display("FAIL single_c4_s_read: got %b expected 0", sa.read[0]); end
        @(negedge clk); #1;
        checks++; if (dut_a.state !== IDLE || dut_a.ptr !== 1'b1) begin errors++; $display("FAIL single_end_fsm: got state %b ptr %b expected 0 1", dut_a.state, dut_a.ptr); end
    endtask

    // Both masters request continuously with an unstalled slave.
    task automatic test_arbitration_order();
        int exp_owner;
        apply_reset();
        ma.read = 2'b11;
        ma.address[0] = 32'h0000_2000;
        ma.address[1] = 32'h0000_3008;
        #1;
        checks++; if (sa.read[0] !== 1'b0) begin errors++; $display("FAIL order_c0_s_read: got %b expected 0", sa.read[0]); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); #1;
`ifdef DBUS_ARB_FIXED_PRIO_EN
            exp_owner = 0;
`else
            exp_owner = (c - 1) % 2;
`endif
            checks++;
            if (sa.read[0] !== 1'b1 || sa.address[0] !== ((exp_owner == 1) ? 32'h0000_3008 : 32'h0000_2000)) begin
                errors++; $display("FAIL order_c%0d_grant: got read %b addr %h expected owner %0d", c, sa.read[0], sa.address[0], exp_owner);
            end
            checks++;
            if (ma.stall !== ((exp_owner == 1) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL order_c%0d_stall: got %b expected owner %0d unstalled", c, ma.stall, exp_owner);
            end
        end
        ma.read = 2'b00;
    endtask

`ifndef DBUS_ARB_FIXED_PRIO_EN
    task automatic test_three_masters();
        apply_reset();
        mb.read[0] = 1'b1;
        mb.address[0] = 32'h0000_0040;
        @(negedge clk);
        @(negedge clk);
        mb.read[0] = 1'b0;
        @(negedge clk); #1;
        checks++; if (dut_b.ptr !== 2'd1 || dut_b.state !== IDLE) begin errors++; $display("FAIL n3_setup_ptr: got ptr %0d state %b expected 1 0", dut_b.ptr, dut_b.state); end
        mb.read = 3'b101;
        mb.address[0] = 32'h0000_0100;
        mb.address[2] = 32'h0000_0200;
        @(negedge clk); #1;
        checks++; if (sb.read[0] !== 1'b1 || sb.address[0] !== 32'h0000_0200) begin errors++; $display("FAIL n3_first_grant: got read %b addr %h expected 1 00000200", sb.read[0], sb.address[0]); end
        checks++; if (mb.stall !== 3'b001) begin errors++; $display("FAIL n3_first_stall: got %b expected 001", mb.stall); end
        @(negedge clk);
        mb.read[2] = 1'b0;
        #1;
        checks++; if (sb.read[0] !== 1'b1 || sb.address[0] !== 32'h0000_0100) begin errors++; $display("FAIL n3_second_grant: got read %b addr %h expected 1 00000100", sb.read[0], sb.address[0]); end
        checks++; if (mb.stall !== 3'b000) begin errors++; $display("FAIL n3_second_stall: got %b expected 000", mb.stall); end
        @(negedge clk);
        mb.read[0] = 1'b0;
        @(negedge clk); #1;
        checks++; if (dut_b.ptr !== 2'd1 || dut_b.state !== IDLE) begin errors++; $display("FAIL n3_end_ptr: got ptr %0d state %b expected 1 0", dut_b.ptr, dut_b.state); end
    endtask
`endif

    task automatic test_flush();
        apply_reset();
        ma.read = 2'b11;
        ma.address[0] = 32'h0000_0500;
        ma.address[1] = 32'h0000_0608;
        sa.stall = 1'b1;
        @(negedge clk); #1;
        checks++; if (sa.read[0] !== 1'b1 || sa.address[0] !== 32'h0000_0500) begin errors++; $display("FAIL flush_grant0: got read %b addr %h expected 1 00000500", sa.read[0], sa.address[0]); end
        checks++; if (ma.stall !== 2'b11) begin errors++; $display("FAIL flush_stall: got %b expected 11", ma.stall); end
        @(negedge clk);
        ma.read[0] = 1'b0;
        #1;
        checks++; if (sa.read[0] !== 1'b0) begin errors++; $display("FAIL flush_drop: got read %b expected 0", sa.read[0]); end
        checks++; if (ma.stall[1] !== 1'b1) begin errors++; $display("FAIL flush_pending_stall: got %b expected 1", ma.stall[1]); end
        @(negedge clk); #1;
        checks++; if (sa.read[0] !== 1'b1 || sa.address[0] !== 32'h0000_0608) begin errors++; $display("FAIL flush_handover: got read %b addr %h expected 1 00000608", sa.read[0], sa.address[0]); end
        checks++; if (dut_a.ptr !== 1'b1) begin errors++; $display("FAIL flush_ptr: got %b expected 1", dut_a.ptr); end
        ma.read = 2'b00;
    endtask

    task automatic test_reset_busy();
        apply_reset();
        ma.uncached_write[1] = 1'b1;
        ma.address[1] = 32'h0000_7008;
        ma.wrdata[1] = 64'h0123_4567_89AB_CDEF;
        ma.byteenable[1] = 8'h0F;
        sa.uncached_stall = 1'b1;
        @(negedge clk); #1;
        checks++; if (sa.uncached_write[0] !== 1'b1 || sa.wrdata[0] !== 64'h0123_4567_89AB_CDEF || sa.byteenable[0] !== 8'h0F) begin
            errors++; $display("FAIL rstbusy_fwd: got uwrite %b data %h be %h expected 1 0123456789abcdef 0f", sa.uncached_write[0], sa.wrdata[0], sa.byteenable[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sa.uncached_write[0] !== 1'b0) begin errors++; $display("FAIL rstbusy_async_drop: got %b expected 0", sa.uncached_write[0]); end
        checks++; if (ma.uncached_stall[1] !== 1'b1) begin errors++; $display("FAIL rstbusy_stall: got %b expected 1", ma.uncached_stall[1]); end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        #1;
        checks++; if (dut_a.state !== IDLE || dut_a.ptr !== 1'b0) begin errors++; $display("FAIL rstbusy_after: got state %b ptr %b expected 0 0", dut_a.state, dut_a.ptr); end
    endtask

    task automatic test_random();
        int          own, ptr;
        logic [1:0]  act, done_flag;
        logic [1:0]  creq, ureq;
        logic [5:0]  exp_str, got_str;
        logic [1:0]  exp_stall, exp_ustall;
        logic [31:0] r;
        int          kind;
        apply_reset();
        own = -1; ptr = 0; act = '0; done_flag = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NA; i++) begin
                if (done_flag[i] || (act[i] && $urandom_range(0, 19) == 0)) begin
                    act[i] = 1'b0;
                    ma.read[i] = 0; ma.write[i] = 0; ma.uncached_read[i] = 0;
                    ma.uncached_write[i] = 0; ma.icache_inv[i] = 0; ma.dcache_inv[i] = 0;
                end
                done_flag[i] = 1'b0;
                if (!act[i] && $urandom_range(0, 2) == 0) begin
                    act[i] = 1'b1;
                    kind = $urandom_range(0, 5);
                    ma.read[i] = (kind == 0); ma.write[i] = (kind == 1);
                    ma.uncached_read[i] = (kind == 2); ma.uncached_write[i] = (kind == 3);
                    ma.icache_inv[i] = (kind == 4); ma.dcache_inv[i] = (kind == 5);
                    r = $urandom;
                    ma.address[i] = {r[31:3], 3'b000};
                    ma.wrdata[i] = {$urandom, $urandom};
                    r = $urandom;
                    ma.byteenable[i] = r[7:0];
                end
            end
            sa.stall[0] = ($urandom_range(0, 2) == 0);
            sa.uncached_stall[0] = ($urandom_range(0, 2) == 0);
            sa.rddata = {$urandom, $urandom};
            sa.uncached_rddata = {$urandom, $urandom};
            #1;
            creq = ma.read | ma.write | ma.icache_inv | ma.dcache_inv;
            ureq = ma.uncached_read | ma.uncached_write;
            exp_str = '0;
            if (own >= 0)
                exp_str = {ma.read[own], ma.write[own], ma.uncached_read[own], ma.uncached_write[own], ma.icache_inv[own], ma.dcache_inv[own]};
            got_str = {sa.read[0], sa.write[0], sa.uncached_read[0], sa.uncached_write[0], sa.icache_inv[0], sa.dcache_inv[0]};
            exp_stall = creq;
            exp_ustall = ureq;
            if (own >= 0) begin
                exp_stall[own] = sa.stall[0];
                exp_ustall[own] = sa.uncached_stall[0];
            end
            checks++; if (got_str !== exp_str) begin errors++; $display("FAIL rand_strobes cyc %0d: got %b expected %b", cyc, got_str, exp_str); end
            if (own >= 0) begin
                checks++;
                if (sa.address[0] !== ma.address[own] || sa.wrdata[0] !== ma.wrdata[own] || sa.byteenable[0] !== ma.byteenable[own]) begin
                    errors++; $display("FAIL rand_payload cyc %0d: got addr %h data %h be %h expected owner %0d payload", cyc, sa.address[0], sa.wrdata[0], sa.byteenable[0], own);
                end
            end
            checks++; if (ma.stall !== exp_stall) begin errors++; $display("FAIL rand_stall cyc %0d: got %b expected %b", cyc, ma.stall, exp_stall); end
            checks++; if (ma.uncached_stall !== exp_ustall) begin errors++; $display("FAIL rand_ustall cyc %0d: got %b expected %b", cyc, ma.uncached_stall, exp_ustall); end
            checks++; if (ma.rddata !== sa.rddata || ma.uncached_rddata !== sa.uncached_rddata) begin errors++; $display("FAIL rand_rddata cyc %0d: got %h %h expected %h %h", cyc, ma.rddata, ma.uncached_rddata, sa.rddata, sa.uncached_rddata); end
            // Advance the reference model by one clock.
            if (own < 0) begin
                own = ref_pick(creq | ureq, ptr);
            end else if ((!creq[own] || !sa.stall[0]) && (!ureq[own] || !sa.uncached_stall[0])) begin
                if (creq[own] || ureq[own]) done_flag[own] = 1'b1;
                ptr = (own + 1) % NA;
                own = ref_pick(creq | ureq, ptr);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_arbitration_order();
`ifndef DBUS_ARB_FIXED_PRIO_EN
        test_three_masters();
`endif
        test_flush();
        test_reset_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
